// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster FSMs plus a PIX_LAT-deep sync/blank/colour alignment pipe to the ADV7123 DAC.
// Define VGA_BORDER_EN to force full-scale colour on the outermost active rows and columns.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_LAT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [9:0]  i_red,
  input  logic [9:0]  i_green,
  input  logic [9:0]  i_blue,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_active,
  output logic        o_frame_start,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_blank_n,
  output logic        o_vga_sync_n,
  output logic [9:0]  o_vga_r,
  output logic [9:0]  o_vga_g,
  output logic [9:0]  o_vga_b
);
  if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_timing_ctrl: PIX_LAT must be in 0..4");
  end
  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_e;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_e;
  h_state_e h_st_q;
  v_state_e v_st_q;
  logic [10:0] h_cnt_q, v_cnt_q, h_end, v_end, h_off, v_off;
  logic h_last, v_last, line_end, frame_end, brd, frame_start_q;
  logic [3:0] raw, tap;
  logic [PIX_LAT+1:0][3:0] chain;
  logic [PIX_LAT:0][3:0] pipe_q;
  logic [9:0] r_q, g_q, b_q, r_d, g_d, b_d;
  always_comb begin
    h_end = h_st_q == HS_ACT ? 11'(H_ACTIVE - 1) : h_st_q == HS_FP ? 11'(H_FP - 1) :
            h_st_q == HS_SYNC ? 11'(H_SYNC - 1) : 11'(H_BP - 1);
    h_off = h_st_q == HS_ACT ? 11'd0 : h_st_q == HS_FP ? 11'(H_ACTIVE) :
            h_st_q == HS_SYNC ? 11'(H_ACTIVE + H_FP) : 11'(H_ACTIVE + H_FP + H_SYNC);
    v_end = v_st_q == VS_ACT ? 11'(V_ACTIVE - 1) : v_st_q == VS_FP ? 11'(V_FP - 1) :
            v_st_q == VS_SYNC ? 11'(V_SYNC - 1) : 11'(V_BP - 1);
    v_off = v_st_q == VS_ACT ? 11'd0 : v_st_q == VS_FP ? 11'(V_ACTIVE) :
            v_st_q == VS_SYNC ? 11'(V_ACTIVE + V_FP) : 11'(V_ACTIVE + V_FP + V_SYNC);
    h_last = h_cnt_q == h_end;
    v_last = v_cnt_q == v_end;
    line_end = i_en && h_last && h_st_q == HS_BP;
    frame_end = line_end && v_last && v_st_q == VS_BP;
    o_x = h_off + h_cnt_q;
    o_y = v_off + v_cnt_q;
    o_active = h_st_q == HS_ACT && v_st_q == VS_ACT;
  end
`ifdef VGA_BORDER_EN
  assign brd = o_x == 11'd0 || o_x == 11'(H_ACTIVE - 1) || o_y == 11'd0 || o_y == 11'(V_ACTIVE - 1);
`else
  assign brd = 1'b0;
`endif
  // Pipe bits {active, border, vs, hs}; tap is what enters the last stage on this tick,
  // which is exactly when the generator returns that pixel's colour.
  always_comb begin
    raw = {o_active, brd, v_st_q != VS_SYNC, h_st_q != HS_SYNC};
    chain = {pipe_q, raw};
    tap = chain[PIX_LAT];
    r_d = !tap[3] ? 10'd0 : tap[2] ? 10'h3FF : i_red;
    g_d = !tap[3] ? 10'd0 : tap[2] ? 10'h3FF : i_green;
    b_d = !tap[3] ? 10'd0 : tap[2] ? 10'h3FF : i_blue;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_st_q <= HS_ACT;
      h_cnt_q <= '0;
      v_st_q <= VS_ACT;
      v_cnt_q <= '0;
    end else if (i_en) begin
      h_cnt_q <= h_last ? '0 : h_cnt_q + 11'd1;
      if (h_last) h_st_q <= h_state_e'(h_st_q + 2'd1);
      if (line_end) begin
        v_cnt_q <= v_last ? '0 : v_cnt_q + 11'd1;
        if (v_last) v_st_q <= v_state_e'(v_st_q + 2'd1);
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_q <= {(PIX_LAT + 1){4'b0011}};
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_end;
      if (i_en) begin
        pipe_q <= chain[PIX_LAT:0];
        r_q <= r_d;
        g_q <= g_d;
        b_q <= b_d;
      end
    end
  end
  assign o_frame_start = frame_start_q;
  assign o_vga_hs = pipe_q[PIX_LAT][0];
  assign o_vga_vs = pipe_q[PIX_LAT][1];
  assign o_vga_blank_n = pipe_q[PIX_LAT][3];
  assign o_vga_sync_n = 1'b0;
  assign o_vga_r = r_q;
  assign o_vga_g = g_q;
  assign o_vga_b = b_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks on a full-size PIX_LAT=0 raster and a miniature PIX_LAT=2 raster.
module tb_vga_timing_ctrl;
`ifdef VGA_BORDER_EN
  localparam bit BRD = 1'b1;
`else
  localparam bit BRD = 1'b0;
`endif
  logic clk = 1'b0, rst_n, en;
  always #5 clk = ~clk;
  logic [10:0] x0, y0, x1, y1, g1_q, g2_q;
  logic act0, fs0, hs0, vs0, bl0, sn0, act1, fs1, hs1, vs1, bl1, sn1;
  logic [9:0] r0, g0, b0, r1, g1, b1, red0, red1;
  int checks = 0, errors = 0;
  assign red0 = x0[9:0];
  assign red1 = g2_q[9:0];
  always @(posedge clk) if (en) begin
    g1_q <= x1;
    g2_q <= g1_q;
  end
  vga_timing_ctrl dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_red(red0), .i_green(10'h155), .i_blue(10'h2AA),
    .o_x(x0), .o_y(y0), .o_active(act0), .o_frame_start(fs0), .o_vga_hs(hs0), .o_vga_vs(vs0),
    .o_vga_blank_n(bl0), .o_vga_sync_n(sn0), .o_vga_r(r0), .o_vga_g(g0), .o_vga_b(b0));
  vga_timing_ctrl #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                    .V_SYNC(2), .V_BP(1), .PIX_LAT(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_red(red1), .i_green(10'h155), .i_blue(10'h2AA),
    .o_x(x1), .o_y(y1), .o_active(act1), .o_frame_start(fs1), .o_vga_hs(hs1), .o_vga_vs(vs1),
    .o_vga_blank_n(bl1), .o_vga_sync_n(sn1), .o_vga_r(r1), .o_vga_g(g1), .o_vga_b(b1));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Miniature raster: 15 ticks/line, 8 lines/frame; outputs trail the coordinate by 3 ticks.
  function automatic logic [63:0] exp1(input int t, input bit tick);
    int k, xk, yk;
    bit hs, vs, act, brd, fs;
    logic [9:0] r, g, b;
    hs = 1; vs = 1; act = 0; r = 0; g = 0; b = 0;
    k = t - 3;
    if (k >= 0) begin
      xk = k % 15;
      yk = (k / 15) % 8;
      hs = !(xk >= 10 && xk < 13);
      vs = !(yk >= 5 && yk < 7);
      act = xk < 8 && yk < 4;
      brd = BRD && (xk == 0 || xk == 7 || yk == 0 || yk == 3);
      r = !act ? 10'd0 : brd ? 10'h3FF : 10'(xk);
      g = !act ? 10'd0 : brd ? 10'h3FF : 10'h155;
      b = !act ? 10'd0 : brd ? 10'h3FF : 10'h2AA;
    end
    fs = tick && t > 0 && t % 120 == 0;
    return 64'({fs, (t % 15) < 8 && ((t / 15) % 8) < 4, hs, vs, act, r, g, b,
                11'(t % 15), 11'((t / 15) % 8)});
  endfunction
  initial begin
    int hs_l0, hs_l1, bl_l0, bl_l1, hs_first, vs_low, fs_cnt, t;
    logic [9:0] r_n1, r_n640, r_n700, r_n900, g_n900;
    logic [10:0] x_n799, y_n799, x_n800, y_n800;
    logic act_n639, act_n640, hs_n2300;
    hs_l0 = 0; hs_l1 = 0; bl_l0 = 0; bl_l1 = 0; hs_first = 0; vs_low = 0; fs_cnt = 0;
    rst_n = 0; en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset0", 64'({fs0, hs0, vs0, bl0, sn0, r0, g0, b0, x0, y0}), 64'({5'b01100, 52'd0}));
    chk("reset1", 64'({fs1, hs1, vs1, bl1, sn1, r1, g1, b1, x1, y1}), 64'({5'b01100, 52'd0}));
    en = 1; rst_n = 1;
    for (int n = 1; n <= 2300; n++) begin
      @(posedge clk);
      #1;
      if (n <= 800) begin
        if (!hs0) hs_l0++;
        if (bl0) bl_l0++;
        if (!hs0 && hs_first == 0) hs_first = n;
      end else if (n <= 1600) begin
        if (!hs0) hs_l1++;
        if (bl0) bl_l1++;
      end
      if (!vs0) vs_low++;
      if (fs0) fs_cnt++;
      if (n == 1) r_n1 = r0;
      if (n == 639) act_n639 = act0;
      if (n == 640) begin r_n640 = r0; act_n640 = act0; end
      if (n == 700) r_n700 = r0;
      if (n == 799) begin x_n799 = x0; y_n799 = y0; end
      if (n == 800) begin x_n800 = x0; y_n800 = y0; end
      if (n == 900) begin r_n900 = r0; g_n900 = g0; end
      if (n == 2300) hs_n2300 = hs0;
    end
    chk("hs_first", 64'(hs_first), 64'd657);
    chk("hs_width_l0", 64'(hs_l0), 64'd96);
    chk("hs_width_l1", 64'(hs_l1), 64'd96);
    chk("blank_l0", 64'(bl_l0), 64'd640);
    chk("blank_l1", 64'(bl_l1), 64'd640);
    chk("vs_idle", 64'(vs_low), 64'd0);
    chk("fs_idle", 64'(fs_cnt), 64'd0);
    chk("x_wrap", 64'({x_n799, y_n799, x_n800, y_n800}), 64'({11'd799, 11'd0, 11'd0, 11'd1}));
    chk("active_edge", 64'({act_n639, act_n640}), 64'(2'b10));
    chk("r_first", 64'(r_n1), BRD ? 64'h3FF : 64'd0);
    chk("r_last", 64'(r_n640), BRD ? 64'h3FF : 64'd639);
    chk("r_blank", 64'(r_n700), 64'd0);
    chk("rg_mid", 64'({r_n900, g_n900}), 64'({10'd99, 10'h155}));
    chk("hs_pre_rst", 64'(hs_n2300), 64'd0);
    rst_n = 0;
    #1;
    chk("async_rst", 64'({hs0, vs0, bl0, r0, x0, y0}), 64'({3'b110, 32'd0}));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    t = 0;
    for (int c = 0; c < 520; c++) begin
      en = (c % 4) == 0;
      @(posedge clk);
      #1;
      if (en) t++;
      chk("mini", 64'({fs1, act1, hs1, vs1, bl1, r1, g1, b1, x1, y1}), exp1(t, en));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Sequences the VGA pattern datapath. Generates horizontal/vertical raster counters, presents them as pixel coordinates to the pattern generator, and captures the generator's returned colour. Emits sync, blank and colour to the ADV7123 DAC with all signals aligned for a configurable generator latency. Sits between the 25 MHz pixel-enable tick and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
PIX_LAT, 0, generator latency in pixel ticks from o_x/o_y to valid i_red/i_green/i_blue (0..4)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset
i_en  in  1  pixel tick; all raster state advances only when high
i_red  in  10  generator red for coordinate issued PIX_LAT ticks earlier
i_green  in  10  generator green, same timing
i_blue  in  10  generator blue, same timing
o_x  out  11  current horizontal count 0..H_TOTAL-1, to generator
o_y  out  11  current vertical count 0..V_TOTAL-1, to generator
o_active  out  1  o_x < H_ACTIVE and o_y < V_ACTIVE (undelayed)
o_frame_start  out  1  one i_clk pulse when raster returns to (0,0)
o_vga_hs  out  1  hsync, active low
o_vga_vs  out  1  vsync, active low
o_vga_blank_n  out  1  high during delayed active region
o_vga_sync_n  out  1  tied 0 (no sync-on-green)
o_vga_r  out  10  DAC red
o_vga_g  out  10  DAC green
o_vga_b  out  10  DAC blue

Behaviour:
- Reset i_rst_n, asynchronous, active-low; clock i_clk.
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- Reset values: o_x=0, o_y=0, o_frame_start=0, o_vga_hs=1, o_vga_vs=1, o_vga_blank_n=0, rgb=0, delay pipeline cleared to inactive (hs=1, vs=1, active=0); H FSM=H_ACT, V FSM=V_ACT.
- H FSM states H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT; per-state counter, transition when counter reaches state length-1 on an i_en tick. o_x is the running line position (state offset + counter).
- V FSM identical structure (V_ACT/V_FP/V_SYNC/V_BP); advances one line only on the i_en tick where H FSM leaves H_BP.
- Coordinates are NOT clamped in blanking: o_x reaches 640..799, o_y reaches 480..524; generator relies on (640,480) appearing exactly once per frame.
- Raw hs = (H state == H_SYNC) ? 0 : 1; raw vs likewise on V_SYNC.
- Delay line of PIX_LAT+1 stages for raw hs, vs, active; each stage shifts only on i_en. Colour inputs registered on the i_en tick when the delay line is at stage PIX_LAT, so output colour, blank_n and syncs change together.
- rgb forced to 0 whenever delayed active is 0, regardless of inputs.
- o_frame_start: high for exactly one i_clk cycle, the cycle following the i_en tick where (H_TOTAL-1, V_TOTAL-1) wraps to (0,0). Not asserted out of reset.
- i_en low: all counters, FSMs, pipeline and outputs hold. i_en held high continuously is legal (raster runs at i_clk).
- Async reset mid-frame: everything returns to reset values immediately; first frame after release restarts at (0,0) with no o_frame_start pulse for it.
- PIX_LAT outside 0..4 is a synthesis-time error.

Optional Feature:
VGA_BORDER_EN: when defined, delayed pixels at x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 drive rgb=10'h3FF, overriding generator colour (border positions travel through the same delay line). When undefined, no override; generator colour passes unchanged.

Test Plan:
- Reset then release, i_en=1 -> outputs at reset values; o_x counts 0..799 then wraps to 0, o_y increments by 1.
- i_en=1 continuously, PIX_LAT=0 -> o_vga_hs low for exactly 96 cycles starting 657 cycles after line start (656 + 1 output stage); blank_n high exactly 640 cycles per line.
- Full frame -> o_vga_vs low for exactly 2 lines starting at line 490 (delayed); o_frame_start single pulse every 420000 enabled ticks.
- i_en asserted 1 of 4 cycles -> all timing counts identical in ticks; outputs stable across non-tick cycles.
- PIX_LAT=2, generator model with 2-tick latency returning red=x[9:0] -> o_vga_r equals 0 on first blank_n-high cycle, 639 on last; rgb=0 while blank_n=0 despite nonzero inputs.
- VGA_BORDER_EN defined, generator rgb=0 -> rgb=3FF on row 0, row 479, col 0, col 639 only; assert reset mid-line -> blank_n=0, hs=1 same cycle.
